// File: rtl/ddr_timing_pkg.sv
// Shared DDR refresh timing types and default constants.
package ddr_timing_pkg;

  typedef enum logic [1:0] {IDLE, OWED, URGENT} ref_state_t;

  localparam int TREFI_CYCLES_DEF  = 780;
  localparam int CNT_WIDTH_DEF     = 16;
  localparam int MAX_PENDING_DEF   = 8;
  localparam int URGENT_THRESH_DEF = 6;

endpackage

// File: rtl/interval_counter.sv
// Free-running tREFI interval counter with a registered one-cycle tick per interval.
module interval_counter #(
  parameter int TREFI_CYCLES = 780,
  parameter int CNT_WIDTH    = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TREFI_CYCLES - 1);

  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 tick_q, tick_d;

  // Disabling mid-interval freezes the partial count rather than restarting it.
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      if (count_q == LAST) begin
        count_d = '0;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/refresh_scheduler.sv
// Tracks owed DRAM refreshes per tREFI interval and requests them from the command arbiter.
module refresh_scheduler
  import ddr_timing_pkg::*;
#(
  parameter int TREFI_CYCLES  = TREFI_CYCLES_DEF,
  parameter int CNT_WIDTH     = CNT_WIDTH_DEF,
  parameter int MAX_PENDING   = MAX_PENDING_DEF,
  parameter int URGENT_THRESH = URGENT_THRESH_DEF
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       enable,
  input  logic       sr_entry,
  input  logic       ref_ack,
  output logic       ref_req,
  output logic       ref_urgent,
  output logic [3:0] pending_cnt,
  output logic       overflow_err
);

  localparam logic [3:0] MAX_P = 4'(MAX_PENDING);
  localparam logic [3:0] URG_T = 4'(URGENT_THRESH);

  logic       tick;
  logic       ack_ok;
  logic [3:0] pending_q, pending_d;
  logic       ovf_q, ovf_d;
  ref_state_t state_q, state_d;

  interval_counter #(
    .TREFI_CYCLES (TREFI_CYCLES),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_intv (
    .clk    (clk),
    .n_rst  (n_rst),
    .enable (enable),
    .clear  (sr_entry),
    .tick   (tick)
  );

  // Handshake: ref_req stays high while any refresh is owed; a REF is consumed
  // only on a cycle with ref_req && ref_ack, and ack without req is ignored.
  assign ack_ok = (state_q != IDLE) && ref_ack;

  always_comb begin
    pending_d = pending_q;
    ovf_d     = ovf_q;
    if (sr_entry) begin
      pending_d = '0;
    end else if (tick && !ack_ok) begin
      if (pending_q == MAX_P) ovf_d = 1'b1;
      else                    pending_d = pending_q + 4'd1;
    end else if (ack_ok && !tick && (pending_q != 4'd0)) begin
      pending_d = pending_q - 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pending_d >= URG_T)      state_d = URGENT;
        else if (pending_d != 4'd0)  state_d = OWED;
      end
      OWED: begin
        if (pending_d == 4'd0)       state_d = IDLE;
        else if (pending_d >= URG_T) state_d = URGENT;
      end
      URGENT: begin
        if (pending_d == 4'd0)       state_d = IDLE;
        else if (pending_d < URG_T)  state_d = OWED;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pending_q <= '0;
      ovf_q     <= 1'b0;
      state_q   <= IDLE;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
    end
  end

  assign ref_req      = (state_q != IDLE);
  assign ref_urgent   = (state_q == URGENT);
  assign pending_cnt  = pending_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_refresh_scheduler.sv
// Directed bench for refresh_scheduler with TREFI_CYCLES=10.
module tb_refresh_scheduler;

  logic       clk;
  logic       n_rst;
  logic       enable;
  logic       sr_entry;
  logic       ref_ack;
  logic       ref_req;
  logic       ref_urgent;
  logic [3:0] pending_cnt;
  logic       overflow_err;

  int total = 0;
  int bad   = 0;

  // {pending_cnt, ref_req, ref_urgent, overflow_err}
  logic [6:0] exp_q[$];

  refresh_scheduler #(
    .TREFI_CYCLES  (10),
    .CNT_WIDTH     (8),
    .MAX_PENDING   (8),
    .URGENT_THRESH (6)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (enable),
    .sr_entry     (sr_entry),
    .ref_ack      (ref_ack),
    .ref_req      (ref_req),
    .ref_urgent   (ref_urgent),
    .pending_cnt  (pending_cnt),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [3:0] p, input logic req, input logic urg, input logic ovf);
    exp_q.push_back({p, req, urg, ovf});
  endtask

  task automatic check_out(input string tag);
    logic [6:0] exp;
    logic [6:0] obs;
    obs = {pending_cnt, ref_req, ref_urgent, overflow_err};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: got %h but expected queue empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        bad++;
        $error("FAIL %s: got pend/req/urg/ovf=%h want %h", tag, obs, exp);
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_rst = 1'b0; enable = 1'b1; sr_entry = 1'b0; ref_ack = 1'b0;
    #1;
    expect_out(4'd0, 1'b0, 1'b0, 1'b0); check_out("reset");
    @(negedge clk);
    n_rst = 1'b1;

    step(9);  check_val("tick_e9", 16'(dut.u_intv.tick_q), 16'd0);
    step(1);  check_val("tick_e10", 16'(dut.u_intv.tick_q), 16'd1);
    expect_out(4'd0, 1'b0, 1'b0, 1'b0); check_out("pend_e10");
    step(1);  expect_out(4'd1, 1'b1, 1'b0, 1'b0); check_out("first_pend");
    check_val("tick_e11", 16'(dut.u_intv.tick_q), 16'd0);

    ref_ack = 1'b1;
    step(1);  expect_out(4'd0, 1'b0, 1'b0, 1'b0); check_out("ack_drain");
    step(1);  expect_out(4'd0, 1'b0, 1'b0, 1'b0); check_out("ack_no_req");
    ref_ack = 1'b0;

    step(48); expect_out(4'd5, 1'b1, 1'b0, 1'b0); check_out("pend5");
    step(10); expect_out(4'd6, 1'b1, 1'b1, 1'b0); check_out("urgent_rise");
    ref_ack = 1'b1;
    step(1);  expect_out(4'd5, 1'b1, 1'b0, 1'b0); check_out("urgent_fall");
    ref_ack = 1'b0;

    step(29); expect_out(4'd8, 1'b1, 1'b1, 1'b0); check_out("pend_max");
    step(10); expect_out(4'd8, 1'b1, 1'b1, 1'b1); check_out("overflow");
    ref_ack = 1'b1;
    step(1);  expect_out(4'd7, 1'b1, 1'b1, 1'b1); check_out("ovf_sticky");
    step(4);  expect_out(4'd3, 1'b1, 1'b0, 1'b1); check_out("drain_to3");
    ref_ack = 1'b0;

    step(4);  check_val("tick_e120", 16'(dut.u_intv.tick_q), 16'd1);
    ref_ack = 1'b1;
    step(1);  expect_out(4'd3, 1'b1, 1'b0, 1'b1); check_out("tick_and_ack");
    ref_ack = 1'b0;
    step(10); expect_out(4'd4, 1'b1, 1'b0, 1'b1); check_out("pend4");
    step(10); expect_out(4'd5, 1'b1, 1'b0, 1'b1); check_out("pend5b");
    step(9);  check_val("tick_e150", 16'(dut.u_intv.tick_q), 16'd1);
    sr_entry = 1'b1;
    step(1);  expect_out(4'd0, 1'b0, 1'b0, 1'b1); check_out("sr_entry");
    sr_entry = 1'b0;
    step(9);  check_val("tick_after_sr_e9", 16'(dut.u_intv.tick_q), 16'd0);
    step(1);  check_val("tick_after_sr_e10", 16'(dut.u_intv.tick_q), 16'd1);
    step(1);  expect_out(4'd1, 1'b1, 1'b0, 1'b1); check_out("pend_after_sr");

    step(3);  check_val("count_at4", 16'(dut.u_intv.count_q), 16'd4);
    enable = 1'b0; ref_ack = 1'b1;
    step(1);  expect_out(4'd0, 1'b0, 1'b0, 1'b1); check_out("ack_while_disabled");
    ref_ack = 1'b0;
    for (int i = 0; i < 19; i++) begin
      step(1); check_val("no_tick_disabled", 16'(dut.u_intv.tick_q), 16'd0);
    end
    check_val("count_held", 16'(dut.u_intv.count_q), 16'd4);
    enable = 1'b1;
    step(5);  check_val("tick_reen_e5", 16'(dut.u_intv.tick_q), 16'd0);
    step(1);  check_val("tick_reen_e6", 16'(dut.u_intv.tick_q), 16'd1);
    step(1);  expect_out(4'd1, 1'b1, 1'b0, 1'b1); check_out("pend_reen");

    step(30); expect_out(4'd4, 1'b1, 1'b0, 1'b1); check_out("pend4_pre_rst");
    #2;
    n_rst = 1'b0;
    #1;
    expect_out(4'd0, 1'b0, 1'b0, 1'b0); check_out("async_reset");
    check_val("count_async_reset", 16'(dut.u_intv.count_q), 16'd0);
    @(negedge clk);
    n_rst = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
